// File: rtl/conv_encoder_framed_pkg.sv
// Shared types, defaults and the parity helper for the framed convolutional encoder.
// The bench model uses the same parity helper.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_t;

    localparam int          K_DEF         = 3;
    localparam int          K_MAX         = 9;
    localparam int unsigned G0_DEF        = 'b111;
    localparam int unsigned G1_DEF        = 'b101;
    localparam int          FRAME_LEN_DEF = 256;

    // Windows and generators are zero-extended to K_MAX bits before the call.
    function automatic logic parity(input logic [K_MAX-1:0] w, input logic [K_MAX-1:0] g);
        return ^(w & g);
    endfunction

endpackage

// File: rtl/conv_encoder_framed_core.sv
// Shift register plus generator parities.
// The caller decides when a step happens and whether the new bit is forced to zero.
module conv_core
    import conv_pkg::*;
#(
    parameter int          K  = K_DEF,
    parameter int unsigned G0 = G0_DEF,
    parameter int unsigned G1 = G1_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       step,
    input  logic       force_zero,
    input  logic       d_in,
    output logic [1:0] sym
);

    logic [K-2:0] sr;
    logic [K-1:0] w;

    assign w   = {force_zero ? 1'b0 : d_in, sr};
    assign sym = {parity(K_MAX'(w), K_MAX'(G0)), parity(K_MAX'(w), K_MAX'(G1))};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (step) begin
            sr <= w[K-1:1];
        end
    end

endmodule

// File: rtl/conv_encoder_framed.sv
// Rate-1/2 convolutional encoder with per-bit handshake, framing and zero-tail flush.
// Each frame carries FRAME_LEN data symbols followed by K-1 tail symbols.
module conv_encoder_framed
    import conv_pkg::*;
#(
    parameter int          K         = K_DEF,
    parameter int unsigned G0        = G0_DEF,
    parameter int unsigned G1        = G1_DEF,
    parameter int          FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        enable_i,
    input  logic        d_in,
    output logic        ready_o,
    output logic        valid_o,
    output logic [1:0]  d_out,
    output logic        frame_last_o,
    output logic        busy_o,
    output logic [15:0] frame_cnt_o
);

    localparam int BCW = $clog2(FRAME_LEN + 1);
    localparam int TCW = ($clog2(K) < 1) ? 1 : $clog2(K);

    enc_state_t     state, state_n;
    logic [BCW-1:0] bit_cnt, bit_cnt_n;
    logic [TCW-1:0] tail_cnt, tail_cnt_n;
    logic [15:0]    frame_cnt_n;
    logic           last_n;
    logic           in_tail, accept, step;
    logic [1:0]     sym;

    assign in_tail = (state == TAIL);
    assign ready_o = !in_tail;
    assign busy_o  = (state != IDLE);
    assign accept  = enable_i & ready_o & ~clr_i;
    assign step    = accept | (in_tail & ~clr_i);

    conv_core #(.K(K), .G0(G0), .G1(G1)) u_core (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr_i),
        .step       (step),
        .force_zero (in_tail),
        .d_in       (d_in),
        .sym        (sym)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        tail_cnt_n  = tail_cnt;
        frame_cnt_n = frame_cnt_o;
        last_n      = 1'b0;
        if (clr_i) begin
            state_n    = IDLE;
            bit_cnt_n  = '0;
            tail_cnt_n = '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    bit_cnt_n  = BCW'(1);
                    tail_cnt_n = '0;
                    state_n    = (FRAME_LEN == 1) ? TAIL : DATA;
                end
                DATA: if (accept) begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt_n == BCW'(FRAME_LEN)) begin
                        state_n    = TAIL;
                        tail_cnt_n = '0;
                    end
                end
                TAIL: begin
                    // The flush step that empties the register closes the frame.
                    if (tail_cnt == TCW'(K - 2)) begin
                        state_n     = IDLE;
                        bit_cnt_n   = '0;
                        tail_cnt_n  = '0;
                        last_n      = 1'b1;
                        frame_cnt_n = frame_cnt_o + 1'b1;
                    end else begin
                        tail_cnt_n = tail_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            tail_cnt     <= '0;
            frame_cnt_o  <= '0;
            valid_o      <= 1'b0;
            d_out        <= 2'b00;
            frame_last_o <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            tail_cnt     <= tail_cnt_n;
            frame_cnt_o  <= frame_cnt_n;
            valid_o      <= step;
            frame_last_o <= last_n;
            if (step) begin
                d_out <= sym;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Self-checking bench: directed FRAME_LEN=4 scenarios plus random 256-bit frames
// scored against a convolution model built from the generator taps.
module tb_conv_encoder_framed;
    import conv_pkg::*;

    localparam int          K   = 3;
    localparam int unsigned G0  = 'b111;
    localparam int unsigned G1  = 'b101;
    localparam int          SL  = 4;
    localparam int          LL  = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        s_clr = 0, s_en = 0, s_d = 0;
    logic        s_ready, s_valid, s_last, s_busy;
    logic [1:0]  s_dout;
    logic [15:0] s_fcnt;

    logic        l_clr = 0, l_en = 0, l_d = 0;
    logic        l_ready, l_valid, l_last, l_busy;
    logic [1:0]  l_dout;
    logic [15:0] l_fcnt;

    int checks = 0;
    int errors = 0;

    logic [1:0] sym_ref [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    logic [2:0] l_exp [$];

    always #5 clk = ~clk;

    conv_encoder_framed #(.K(K), .G0(G0), .G1(G1), .FRAME_LEN(SL)) u_dut (
        .clk(clk), .rst(rst), .clr_i(s_clr), .enable_i(s_en), .d_in(s_d),
        .ready_o(s_ready), .valid_o(s_valid), .d_out(s_dout),
        .frame_last_o(s_last), .busy_o(s_busy), .frame_cnt_o(s_fcnt)
    );

    conv_encoder_framed #(.K(K), .G0(G0), .G1(G1), .FRAME_LEN(LL)) u_dut_long (
        .clk(clk), .rst(rst), .clr_i(l_clr), .enable_i(l_en), .d_in(l_d),
        .ready_o(l_ready), .valid_o(l_valid), .d_out(l_dout),
        .frame_last_o(l_last), .busy_o(l_busy), .frame_cnt_o(l_fcnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Symbol j of a zero-terminated frame: taps applied to the last K input bits.
    function automatic logic [1:0] model_sym(input logic data[$], input int j);
        logic [K_MAX-1:0] w;
        w = '0;
        for (int i = 0; i < K; i++) begin
            int idx;
            idx = j - i;
            if (idx >= 0 && idx < data.size()) w[K-1-i] = data[idx];
        end
        return {parity(w, K_MAX'(G0)), parity(w, K_MAX'(G1))};
    endfunction

    always @(negedge clk) begin
        if (rst && l_valid) begin
            if (l_exp.size() == 0) begin
                check("l_extra_valid", l_valid, 0);
            end else begin
                check("l_sym", {l_last, l_dout}, l_exp.pop_front());
            end
        end
    end

    // Sends the frame 1,0,1,1 (optional gap after bit gap_after) and checks every cycle.
    task automatic run_short(input int gap_after, input int gap_len, input logic tail_en,
                             input logic [15:0] fcnt_before);
        logic [3:0] bits;
        bits = 4'b1101;
        for (int i = 0; i < SL; i++) begin
            s_en = 1'b1;
            s_d  = bits[i];
            check("s_ready_data", s_ready, 1);
            tick();
            check("s_valid", s_valid, 1);
            check("s_sym", s_dout, sym_ref[i]);
            check("s_last_data", s_last, 0);
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    s_en = 1'b0;
                    s_d  = 1'($urandom);
                    tick();
                    check("s_gap_valid", s_valid, 0);
                    check("s_gap_ready", s_ready, 1);
                    check("s_gap_busy", s_busy, 1);
                end
            end
        end
        s_en = tail_en;
        s_d  = 1'b1;
        for (int t = 0; t < K - 1; t++) begin
            check("s_ready_tail", s_ready, 0);
            tick();
            check("s_tail_valid", s_valid, 1);
            check("s_tail_sym", s_dout, sym_ref[SL+t]);
            check("s_tail_last", s_last, (t == K - 2) ? 1 : 0);
        end
        s_en = 1'b0;
        check("s_fcnt", s_fcnt, fcnt_before + 16'd1);
        check("s_busy_end", s_busy, 0);
        check("s_ready_end", s_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic data [$];
        int   b;
        logic [15:0] f0;

        #12;
        check("rst_s_ready", s_ready, 1);
        check("rst_s_busy", s_busy, 0);
        check("rst_s_valid", s_valid, 0);
        check("rst_s_dout", s_dout, 0);
        check("rst_s_last", s_last, 0);
        check("rst_s_fcnt", s_fcnt, 0);
        check("rst_l_fcnt", l_fcnt, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Three random 256-bit frames with random input gaps.
        for (int f = 0; f < 3; f++) begin
            data.delete();
            for (int i = 0; i < LL; i++) data.push_back(1'($urandom));
            for (int j = 0; j < LL + K - 1; j++)
                l_exp.push_back({(j == LL + K - 2) ? 1'b1 : 1'b0, model_sym(data, j)});
            for (int i = 0; i < LL; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    l_en = 1'b0;
                    l_d  = 1'($urandom);
                    tick();
                end
                l_en = 1'b1;
                l_d  = data[i];
                b = 0;
                while (!l_ready && b < 10) begin
                    tick();
                    b++;
                end
                if (!l_ready) check("l_ready_timeout", l_ready, 1);
                tick();
            end
        end
        l_en = 1'b0;
        b = 0;
        while (l_exp.size() != 0 && b < 20) begin
            tick();
            b++;
        end
        check("l_drain", l_exp.size(), 0);
        check("l_fcnt", l_fcnt, 3);
        check("l_busy", l_busy, 0);

        // Basic frame, then a frame with a 3-cycle gap.
        run_short(-1, 0, 1'b0, 16'd0);
        run_short(1, 3, 1'b0, 16'd1);

        // enable_i held high through the tail, next frame back-to-back.
        run_short(-1, 0, 1'b1, 16'd2);
        run_short(-1, 0, 1'b0, 16'd3);

        // Synchronous abort after two bits; the bit presented with clr_i is dropped.
        f0 = s_fcnt;
        for (int i = 0; i < 2; i++) begin
            s_en = 1'b1;
            s_d  = (i == 0);
            tick();
            check("clr_pre_sym", s_dout, sym_ref[i]);
        end
        s_clr = 1'b1;
        s_en  = 1'b1;
        s_d   = 1'b1;
        tick();
        s_clr = 1'b0;
        s_en  = 1'b0;
        check("clr_valid", s_valid, 0);
        check("clr_busy", s_busy, 0);
        check("clr_last", s_last, 0);
        check("clr_fcnt", s_fcnt, f0);
        check("clr_ready", s_ready, 1);
        tick();
        check("clr_idle_valid", s_valid, 0);
        run_short(-1, 0, 1'b0, f0);

        // Asynchronous reset in the middle of the tail.
        for (int i = 0; i < SL; i++) begin
            s_en = 1'b1;
            s_d  = i[0];
            tick();
        end
        s_en = 1'b0;
        tick();
        check("pre_rst_valid", s_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", s_valid, 0);
        check("arst_dout", s_dout, 0);
        check("arst_last", s_last, 0);
        check("arst_fcnt", s_fcnt, 0);
        check("arst_busy", s_busy, 0);
        check("arst_ready", s_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_last", s_last, 0);
            check("post_rst_valid", s_valid, 0);
        end
        run_short(-1, 0, 1'b0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
